// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares the single main-memory port between the microcoded CPU controller
//   and a DMA/IO requester. Every access runs IDLE -> BUSY -> DONE: the winner's
//   request is latched on the grant edge, BUSY holds the memory enable for
//   WAIT_CYCLES+1 cycles, and DONE pulses the winner's ack for one cycle.
//   cpu_wait is the stall condition tested by the controller's wait branch.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     CPU request (req held until cpu_ack)
//   cpu_ack, cpu_wait         CPU completion pulse, CPU stall
//   dma_req/we/addr/wdata     DMA request (req held until dma_ack)
//   dma_ack                   DMA completion pulse
//   rdata                     read data, valid in the ack cycle, held until the next read completes
//   mem_en/we/addr/wdata      memory port, driven from the latched request
//   mem_rdata                 memory read data, sampled on the last BUSY cycle
//   busy                      high whenever the arbiter is not IDLE

module mem_bus_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int WAIT_CYCLES  = 2,
    parameter int CPU_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic       GNT_CPU   = 1'b0;
    localparam logic       GNT_DMA   = 1'b1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                any_req;
    logic                winner;

    // Tie-break: fixed CPU priority, or alternate away from the last winner.
    always_comb begin
        any_req = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            winner = (CPU_PRIORITY != 0) ? GNT_CPU : ~last_grant_q;
        end else if (cpu_req) begin
            winner = GNT_CPU;
        end else begin
            winner = GNT_DMA;
        end
    end

    // State register plus the latched request and wait counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            grant_q      <= GNT_CPU;
            last_grant_q <= GNT_DMA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state logic; requests are only looked at while IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching on grant, wait countdown, read capture on the last BUSY cycle.
    always_comb begin
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = WAIT_INIT;
                    we_d         = (winner == GNT_DMA) ? dma_we    : cpu_we;
                    addr_d       = (winner == GNT_DMA) ? dma_addr  : cpu_addr;
                    wdata_d      = (winner == GNT_DMA) ? dma_wdata : cpu_wdata;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (!we_q) begin
                    rdata_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Outputs decode from the state; the ack goes only to the granted side.
    always_comb begin
        mem_en    = (state_q == BUSY);
        mem_we    = (state_q == BUSY) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = (state_q == DONE) && (grant_q == GNT_CPU);
        dma_ack   = (state_q == DONE) && (grant_q == GNT_DMA);
        busy      = (state_q != IDLE);
        rdata     = rdata_q;
        // Drops in the ack cycle so the controller's wait branch falls through.
        cpu_wait  = cpu_req && !cpu_ack;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Three arbiter instances: [0] round-robin with 2 wait states, [1] CPU
//   priority with 2 wait states, [2] round-robin with no wait states.
//   Directed sequences push expected transactions into a queue; a negedge
//   monitor checks memory-port activity and every ack against the queue.

module tb_mem_bus_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a       [3];
    logic          cpu_req_a   [3];
    logic          cpu_we_a    [3];
    logic [AW-1:0] cpu_addr_a  [3];
    logic [DW-1:0] cpu_wdata_a [3];
    logic          cpu_ack_a   [3];
    logic          cpu_wait_a  [3];
    logic          dma_req_a   [3];
    logic          dma_we_a    [3];
    logic [AW-1:0] dma_addr_a  [3];
    logic [DW-1:0] dma_wdata_a [3];
    logic          dma_ack_a   [3];
    logic [DW-1:0] rdata_a     [3];
    logic          mem_en_a    [3];
    logic          mem_we_a    [3];
    logic [AW-1:0] mem_addr_a  [3];
    logic [DW-1:0] mem_wdata_a [3];
    logic [DW-1:0] mem_rdata_a [3];
    logic          busy_a      [3];

    typedef struct packed {
        logic [1:0]    inst;
        logic          is_dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   fails     = 0;
    int   busy_cnt  [3];

    // Memory contents; reads outside BUSY return a poison value.
    function automatic logic [DW-1:0] memModel(input logic [AW-1:0] a);
        case (a)
            12'h005: return 16'h1234;
            12'h010: return 16'h5A10;
            12'h011: return 16'h5A11;
            default: return {4'hC, a};
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            mem_rdata_a[i] = mem_en_a[i] ? memModel(mem_addr_a[i]) : 16'hDEAD;
        end
    end

    function automatic int waitOf(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2), .CPU_PRIORITY(0)) u_rr (
        .clk(clk), .rst(rst_a[0]),
        .cpu_req(cpu_req_a[0]), .cpu_we(cpu_we_a[0]), .cpu_addr(cpu_addr_a[0]),
        .cpu_wdata(cpu_wdata_a[0]), .cpu_ack(cpu_ack_a[0]), .cpu_wait(cpu_wait_a[0]),
        .dma_req(dma_req_a[0]), .dma_we(dma_we_a[0]), .dma_addr(dma_addr_a[0]),
        .dma_wdata(dma_wdata_a[0]), .dma_ack(dma_ack_a[0]), .rdata(rdata_a[0]),
        .mem_en(mem_en_a[0]), .mem_we(mem_we_a[0]), .mem_addr(mem_addr_a[0]),
        .mem_wdata(mem_wdata_a[0]), .mem_rdata(mem_rdata_a[0]), .busy(busy_a[0])
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2), .CPU_PRIORITY(1)) u_pri (
        .clk(clk), .rst(rst_a[1]),
        .cpu_req(cpu_req_a[1]), .cpu_we(cpu_we_a[1]), .cpu_addr(cpu_addr_a[1]),
        .cpu_wdata(cpu_wdata_a[1]), .cpu_ack(cpu_ack_a[1]), .cpu_wait(cpu_wait_a[1]),
        .dma_req(dma_req_a[1]), .dma_we(dma_we_a[1]), .dma_addr(dma_addr_a[1]),
        .dma_wdata(dma_wdata_a[1]), .dma_ack(dma_ack_a[1]), .rdata(rdata_a[1]),
        .mem_en(mem_en_a[1]), .mem_we(mem_we_a[1]), .mem_addr(mem_addr_a[1]),
        .mem_wdata(mem_wdata_a[1]), .mem_rdata(mem_rdata_a[1]), .busy(busy_a[1])
    );

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(0), .CPU_PRIORITY(0)) u_w0 (
        .clk(clk), .rst(rst_a[2]),
        .cpu_req(cpu_req_a[2]), .cpu_we(cpu_we_a[2]), .cpu_addr(cpu_addr_a[2]),
        .cpu_wdata(cpu_wdata_a[2]), .cpu_ack(cpu_ack_a[2]), .cpu_wait(cpu_wait_a[2]),
        .dma_req(dma_req_a[2]), .dma_we(dma_we_a[2]), .dma_addr(dma_addr_a[2]),
        .dma_wdata(dma_wdata_a[2]), .dma_ack(dma_ack_a[2]), .rdata(rdata_a[2]),
        .mem_en(mem_en_a[2]), .mem_we(mem_we_a[2]), .mem_addr(mem_addr_a[2]),
        .mem_wdata(mem_wdata_a[2]), .mem_rdata(mem_rdata_a[2]), .busy(busy_a[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: memory-port contents during BUSY and every ack are checked
    // against the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_a[i]) begin
                busy_cnt[i] = 0;
            end else begin
                if (mem_en_a[i]) begin
                    busy_cnt[i]++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_access", 32'(mem_en_a[i]), 32'd0);
                    end else begin
                        checkOutput("busy_inst", 32'(i), 32'(exp_q[0].inst));
                        checkOutput("mem_we", 32'(mem_we_a[i]), 32'(exp_q[0].we));
                        checkOutput("mem_addr", 32'(mem_addr_a[i]), 32'(exp_q[0].addr));
                        if (exp_q[0].we) begin
                            checkOutput("mem_wdata", 32'(mem_wdata_a[i]), 32'(exp_q[0].wdata));
                        end
                    end
                end
                if (cpu_ack_a[i] || dma_ack_a[i]) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_ack", 32'(cpu_ack_a[i] | dma_ack_a[i]), 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checkOutput("ack_inst", 32'(i), 32'(e.inst));
                        checkOutput("ack_who", 32'({dma_ack_a[i], cpu_ack_a[i]}),
                                    e.is_dma ? 32'd2 : 32'd1);
                        checkOutput("busy_cycles", 32'(busy_cnt[i]), 32'(waitOf(i) + 1));
                        checkOutput("mem_en_in_ack", 32'(mem_en_a[i]), 32'd0);
                        if (!e.we) begin
                            checkOutput("rdata", 32'(rdata_a[i]), 32'(e.rdata));
                        end
                    end
                    busy_cnt[i] = 0;
                end
            end
        end
    end

    task automatic pushExp(input int i, input bit dma, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
        exp_t e;
        e.inst   = 2'(i);
        e.is_dma = dma;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.rdata  = rexp;
        exp_q.push_back(e);
    endtask

    // Counts negedges from the request cycle up to and including the ack cycle.
    task automatic waitAck(input int i, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cpu_ack_a[i] || dma_ack_a[i]) break;
            if (cyc >= 40) begin
                checkOutput("ack_timeout", 32'(cpu_ack_a[i] | dma_ack_a[i]), 32'd1);
                break;
            end
        end
    endtask

    task automatic resetInst(input int i);
        @(posedge clk); #1;
        rst_a[i] = 1'b1;
        @(posedge clk); #1;
        rst_a[i] = 1'b0;
    endtask

    // Single access with cpu_wait and latency checked every cycle.
    task automatic applyStimulus(input int i, input bit dma, input bit we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
        int  cyc;
        logic ack;
        pushExp(i, dma, we, addr, wdata, rexp);
        @(posedge clk); #1;
        if (dma) begin
            dma_req_a[i] = 1'b1; dma_we_a[i] = we; dma_addr_a[i] = addr; dma_wdata_a[i] = wdata;
        end else begin
            cpu_req_a[i] = 1'b1; cpu_we_a[i] = we; cpu_addr_a[i] = addr; cpu_wdata_a[i] = wdata;
        end
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            ack = cpu_ack_a[i] | dma_ack_a[i];
            if (dma) checkOutput("cpu_wait_idle", 32'(cpu_wait_a[i]), 32'd0);
            else     checkOutput("cpu_wait", 32'(cpu_wait_a[i]), (cyc < waitOf(i) + 3) ? 32'd1 : 32'd0);
            if (ack || cyc >= 40) break;
        end
        checkOutput("ack_latency", 32'(cyc), 32'(waitOf(i) + 3));
        @(posedge clk); #1;
        cpu_req_a[i] = 1'b0;
        dma_req_a[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 3; i++) begin
            rst_a[i] = 1'b1;
            cpu_req_a[i] = 1'b0; cpu_we_a[i] = 1'b0; cpu_addr_a[i] = '0; cpu_wdata_a[i] = '0;
            dma_req_a[i] = 1'b0; dma_we_a[i] = 1'b0; dma_addr_a[i] = '0; dma_wdata_a[i] = '0;
            busy_cnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_a[i] = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_mem_en",    32'(mem_en_a[0]),    32'd0);
        checkOutput("rst_mem_we",    32'(mem_we_a[0]),    32'd0);
        checkOutput("rst_mem_addr",  32'(mem_addr_a[0]),  32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata_a[0]), 32'd0);
        checkOutput("rst_busy",      32'(busy_a[0]),      32'd0);
        checkOutput("rst_cpu_ack",   32'(cpu_ack_a[0]),   32'd0);
        checkOutput("rst_dma_ack",   32'(dma_ack_a[0]),   32'd0);
        checkOutput("rst_cpu_wait",  32'(cpu_wait_a[0]),  32'd0);
        checkOutput("rst_rdata",     32'(rdata_a[0]),     32'd0);

        // CPU read, then a DMA write that must leave rdata alone
        applyStimulus(0, 1'b0, 1'b0, 12'h005, 16'h0000, 16'h1234);
        checkOutput("t1_rdata", 32'(rdata_a[0]), 32'h1234);
        applyStimulus(0, 1'b1, 1'b1, 12'h0FF, 16'hBEEF, 16'h0000);
        checkOutput("t2_rdata_held", 32'(rdata_a[0]), 32'h1234);

        // Round-robin tie: CPU, DMA, CPU, DMA with both requests held
        resetInst(0);
        pushExp(0, 1'b0, 1'b0, 12'h020, 16'h0, 16'hC020);
        pushExp(0, 1'b1, 1'b0, 12'h030, 16'h0, 16'hC030);
        pushExp(0, 1'b0, 1'b0, 12'h020, 16'h0, 16'hC020);
        pushExp(0, 1'b1, 1'b0, 12'h030, 16'h0, 16'hC030);
        @(posedge clk); #1;
        cpu_req_a[0] = 1'b1; cpu_we_a[0] = 1'b0; cpu_addr_a[0] = 12'h020;
        dma_req_a[0] = 1'b1; dma_we_a[0] = 1'b0; dma_addr_a[0] = 12'h030;
        for (int k = 0; k < 4; k++) begin
            waitAck(0, cyc);
            checkOutput("rr_period", 32'(cyc), 32'd5);
        end
        @(posedge clk); #1;
        cpu_req_a[0] = 1'b0;
        dma_req_a[0] = 1'b0;

        // Reset in the second BUSY cycle of a CPU read aborts it
        pushExp(0, 1'b0, 1'b0, 12'h040, 16'h0, 16'hC040);
        @(posedge clk); #1;
        cpu_req_a[0] = 1'b1; cpu_addr_a[0] = 12'h040;
        @(posedge clk);
        @(posedge clk); #1;
        rst_a[0] = 1'b1;
        cpu_req_a[0] = 1'b0;
        @(posedge clk); #1;
        rst_a[0] = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_mem_en", 32'(mem_en_a[0]), 32'd0);
        checkOutput("abort_busy",   32'(busy_a[0]),   32'd0);
        checkOutput("abort_rdata",  32'(rdata_a[0]),  32'd0);
        for (int k = 0; k < 5; k++) begin
            checkOutput("abort_no_ack", 32'(cpu_ack_a[0]), 32'd0);
            @(negedge clk);
        end

        // CPU priority: CPU wins every tie; DMA only once the CPU lets go
        resetInst(1);
        pushExp(1, 1'b0, 1'b0, 12'h020, 16'h0, 16'hC020);
        pushExp(1, 1'b0, 1'b0, 12'h020, 16'h0, 16'hC020);
        pushExp(1, 1'b0, 1'b0, 12'h020, 16'h0, 16'hC020);
        pushExp(1, 1'b1, 1'b0, 12'h030, 16'h0, 16'hC030);
        @(posedge clk); #1;
        cpu_req_a[1] = 1'b1; cpu_we_a[1] = 1'b0; cpu_addr_a[1] = 12'h020;
        dma_req_a[1] = 1'b1; dma_we_a[1] = 1'b0; dma_addr_a[1] = 12'h030;
        for (int k = 0; k < 3; k++) begin
            waitAck(1, cyc);
            checkOutput("pri_period", 32'(cyc), 32'd5);
        end
        @(posedge clk); #1;
        cpu_req_a[1] = 1'b0;
        waitAck(1, cyc);
        checkOutput("pri_dma_after", 32'(cyc), 32'd5);
        @(posedge clk); #1;
        dma_req_a[1] = 1'b0;

        // No wait states: back-to-back CPU reads exactly three cycles apart
        pushExp(2, 1'b0, 1'b0, 12'h010, 16'h0, 16'h5A10);
        pushExp(2, 1'b0, 1'b0, 12'h011, 16'h0, 16'h5A11);
        @(posedge clk); #1;
        cpu_req_a[2] = 1'b1; cpu_we_a[2] = 1'b0; cpu_addr_a[2] = 12'h010;
        waitAck(2, cyc);
        checkOutput("w0_first", 32'(cyc), 32'd3);
        checkOutput("w0_rdata0", 32'(rdata_a[2]), 32'h5A10);
        cpu_addr_a[2] = 12'h011;
        waitAck(2, cyc);
        checkOutput("w0_period", 32'(cyc), 32'd3);
        checkOutput("w0_rdata1", 32'(rdata_a[2]), 32'h5A11);
        @(posedge clk); #1;
        cpu_req_a[2] = 1'b0;

        repeat (6) @(negedge clk);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
